// File: rtl/program_loader_pkg.sv
// Shared definitions for the byte-stream program loader: architecture widths,
// the frame start marker and the loader FSM state encoding.
package program_loader_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 8;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        RELEASE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Byte-stream bootloader. Frames of the form SYNC, LEN_LO, LEN_HI, LEN data
// bytes are written to program RAM addresses 0..LEN-1 while the CPU is held
// in reset. The CPU is released once the frame is complete.
// Optional feature macro: LOADER_CHECKSUM_EN appends an 8-bit wrap-sum check
// byte after the data; a mismatch leaves the loader in ERROR with the CPU held.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         ADDR_W    = ADDR_WIDTH,
    parameter int         DATA_W    = DATA_WIDTH,
    parameter logic [7:0] SYNC_BYTE = LOADER_SYNC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              cpu_reset_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    if (DATA_W != 8) begin : g_bad_data_width
        $error("program_loader: DATA_W must be 8");
    end

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_t     state_q;
    logic [7:0]        len_lo_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   idx_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_data_q;
    logic              cpu_reset_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    logic              accept;
    logic [15:0]       len_d;
    logic              len_too_big;
    logic              last_byte;

    assign accept      = rx_valid_i & rx_ready_o;
    assign len_d       = {rx_data_i, len_lo_q};
    // LEN may equal the full RAM size but never exceed it, so idx never wraps.
    assign len_too_big = 32'(len_d) > (32'd1 << ADDR_W);
    assign last_byte   = (idx_q == (len_q - ONE));

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_d;
    assign sum_d = sum_q + rx_data_i;
`endif

    // The only cycle a byte cannot be taken is the one-cycle hand-off to the CPU.
    assign rx_ready_o  = (state_q != RELEASE);
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_data_o  = ram_data_q;
    assign cpu_reset_o = cpu_reset_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

    // Frame FSM with registered outputs; write strobe and done are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            len_lo_q    <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            cpu_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            ram_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE, ERROR: begin
                    // Anything but the sync marker is line noise between frames.
                    if (accept && rx_data_i == SYNC_BYTE) begin
                        state_q     <= LEN_LO;
                        error_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        cpu_reset_q <= 1'b1;
                        idx_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q       <= '0;
`endif
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_lo_q <= rx_data_i;
                        state_q  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        if (len_too_big) begin
                            state_q <= ERROR;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            len_q <= len_d[ADDR_W:0];
                            if (len_d == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                state_q <= CHECK;
`else
                                state_q <= RELEASE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
`endif
                            end else begin
                                state_q <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        ram_we_q   <= 1'b1;
                        ram_addr_q <= idx_q[ADDR_W-1:0];
                        ram_data_q <= DATA_W'(rx_data_i);
                        idx_q      <= idx_q + ONE;
`ifdef LOADER_CHECKSUM_EN
                        sum_q      <= sum_d;
`endif
                        if (last_byte) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q <= CHECK;
`else
                            state_q <= RELEASE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
                CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                    if (accept) begin
                        busy_q <= 1'b0;
                        if (rx_data_i == sum_q) begin
                            state_q <= RELEASE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ERROR;
                            error_q <= 1'b1;
                        end
                    end
`else
                    state_q <= IDLE;
`endif
                end
                RELEASE: begin
                    // CPU leaves reset one cycle after done so it sees a complete image.
                    state_q     <= IDLE;
                    cpu_reset_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: the stimulus side queues the RAM
// writes and done pulses each frame should produce, and a monitor pops and
// compares them as the DUT presents them.
module tb_program_loader;
    import program_loader_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_data;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       error;

    program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .ram_we_o   (ram_we),
        .ram_addr_o (ram_addr),
        .ram_data_o (ram_data),
        .cpu_reset_o(cpu_reset),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_done;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] dq[$];
    int         wcyc[$];
    int         checks = 0;
    int         fails  = 0;
    int         cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe and done pulse must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ram_we) begin
            wcyc.push_back(cyc);
            if (expq.size() == 0) begin
                chk("unexpected_write", {ram_addr, ram_data}, 32'hFFFF_FFFF);
            end else begin
                e = expq.pop_front();
                chk("write_vs_done_order", 32'(e.is_done), 32'd0);
                chk("write_addr", 32'(ram_addr), 32'(e.addr));
                chk("write_data", 32'(ram_data), 32'(e.data));
            end
        end
        if (done) begin
            if (expq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                chk("done_expected", 32'(e.is_done), 32'd1);
            end
        end
    end

    task automatic push_write(input int a, input logic [7:0] d);
        exp_t e;
        e.is_done = 1'b0;
        e.addr    = a[7:0];
        e.data    = d;
        expq.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.addr    = 8'h00;
        e.data    = 8'h00;
        expq.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) chk("ready_timeout", 32'd0, 32'd1);
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic go_idle();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Sends a complete frame with payload dq[0..len-1] and queues its effects.
    task automatic send_frame(input int len);
        logic [7:0] s = 8'h00;
        send_byte(LOADER_SYNC);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        for (int i = 0; i < len; i++) begin
            push_write(i, dq[i]);
            s = s + dq[i];
            send_byte(dq[i]);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(s);
`endif
        push_done();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_ready", 32'(rx_ready), 32'd1);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);

        // Single-byte frame: A5 01 00 F0
        send_byte(8'hA5);
        send_byte(8'h01);
        chk("t1_cpu_reset_held", 32'(cpu_reset), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        send_byte(8'h00);
        push_write(0, 8'hF0);
        send_byte(8'hF0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hF0);
`endif
        push_done();
        go_idle();
        chk("t1_release_cpu_still_held", 32'(cpu_reset), 32'd1);
        chk("t1_release_not_ready", 32'(rx_ready), 32'd0);
        @(negedge clk);
        chk("t1_cpu_released", 32'(cpu_reset), 32'd0);
        chk("t1_busy_clear", 32'(busy), 32'd0);

        // Back-to-back three-byte frame; writes land on consecutive cycles
        wcyc.delete();
        dq = '{8'h11, 8'h22, 8'h33};
        send_frame(3);
        go_idle();
        repeat (2) @(negedge clk);
        chk("t2_write_count", 32'(wcyc.size()), 32'd3);
        if (wcyc.size() == 3) chk("t2_consecutive", 32'(wcyc[2] - wcyc[0]), 32'd2);

        // Leading garbage ignored, zero-length frame just releases
        send_byte(8'h00);
        send_byte(8'hFF);
        chk("t4_garbage_no_busy", 32'(busy), 32'd0);
        send_frame(0);
        go_idle();
        repeat (2) @(negedge clk);
        chk("t4_cpu_released", 32'(cpu_reset), 32'd0);

        // LEN = 257 exceeds 256-word RAM
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        go_idle();
        chk("t5_error", 32'(error), 32'd1);
        chk("t5_cpu_held", 32'(cpu_reset), 32'd1);
        chk("t5_busy_clear", 32'(busy), 32'd0);
        send_byte(8'h77);
        go_idle();
        repeat (2) @(negedge clk);
        chk("t5_error_sticky", 32'(error), 32'd1);
        dq = '{8'h5A};
        send_frame(1);
        go_idle();
        chk("t5_error_cleared", 32'(error), 32'd0);
        @(negedge clk);
        chk("t5_recovered_cpu_released", 32'(cpu_reset), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: 01+02 = 03, not 07
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        push_write(0, 8'h01);
        send_byte(8'h01);
        push_write(1, 8'h02);
        send_byte(8'h02);
        send_byte(8'h07);
        go_idle();
        repeat (2) @(negedge clk);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_cpu_held", 32'(cpu_reset), 32'd1);
        dq = '{8'hC3};
        send_frame(1);
        go_idle();
        chk("t3_error_cleared", 32'(error), 32'd0);
`endif

        // Reset after two of four data bytes
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h00);
        push_write(0, 8'hDE);
        send_byte(8'hDE);
        push_write(1, 8'hAD);
        send_byte(8'hAD);
        @(negedge clk);
        reset   = 1'b1;
        rx_data = 8'hBE;
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        chk("t6_cpu_reset_clear", 32'(cpu_reset), 32'd0);
        chk("t6_busy_clear", 32'(busy), 32'd0);
        chk("t6_ready", 32'(rx_ready), 32'd1);
        dq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(4);
        go_idle();

        // Largest legal frame: LEN = 256 fills every address
        dq.delete();
        for (int i = 0; i < 256; i++) dq.push_back(8'(i) ^ 8'h3C);
        send_frame(256);
        go_idle();
        repeat (3) @(negedge clk);
        chk("t7_cpu_released", 32'(cpu_reset), 32'd0);
        chk("t7_no_error", 32'(error), 32'd0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
